// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_sync block: FSM state encoding
// and glitch-counter sizing.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'b00,
        ST_CHK_HI    = 2'b01,
        ST_STABLE_HI = 2'b10,
        ST_CHK_LO    = 2'b11
    } state_t;

    localparam int                  GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

endpackage

// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw switch source and the debouncer.
// The slave modport is the debouncer side.
interface debounce_sync_if
    import debounce_pkg::*;
();
    logic                din_raw;
    logic                dout;
    logic                rise;
    logic                fall;
    logic                busy;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output din_raw,
        input  dout, rise, fall, busy, glitch_cnt
    );

    modport slave (
        input  din_raw,
        output dout, rise, fall, busy, glitch_cnt
    );
endinterface

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchronizer for one asynchronous input; reusable for any
// asynchronous lab input. q is the last stage.
module sync_chain #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizer plus counter-based debounce FSM for one mechanical input.
// Optional rejected-bounce counter enabled by `define DEBOUNCE_GLITCH_CNT_EN.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    debounce_sync_if.slave   bus
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam state_t           RST_STATE = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

    logic             sync_q;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dout_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.din_raw),
        .q     (sync_q)
    );

    // All outputs are registered alongside the state so busy/rise/fall line up with dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RST_STATE;
            cnt    <= '0;
            dout_q <= RESET_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                ST_STABLE_LO: begin
                    if (sync_q) begin
                        state  <= ST_CHK_HI;
                        cnt    <= CNT_W'(1);
                        busy_q <= 1'b1;
                    end
                end
                ST_CHK_HI: begin
                    if (!sync_q) begin
                        state  <= ST_STABLE_LO;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= ST_STABLE_HI;
                        cnt    <= '0;
                        dout_q <= 1'b1;
                        rise_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STABLE_HI: begin
                    if (!sync_q) begin
                        state  <= ST_CHK_LO;
                        cnt    <= CNT_W'(1);
                        busy_q <= 1'b1;
                    end
                end
                ST_CHK_LO: begin
                    if (sync_q) begin
                        state  <= ST_STABLE_HI;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= ST_STABLE_LO;
                        cnt    <= '0;
                        dout_q <= 1'b0;
                        fall_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= RST_STATE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout = dout_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                reject;
    logic [GLITCH_W-1:0] glitch_q;

    // A rejected change is any qualification that falls back to its stable state.
    always_comb begin
        reject = ((state == ST_CHK_HI) && !sync_q) || ((state == ST_CHK_LO) && sync_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else if (reject && (glitch_q != GLITCH_MAX)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign bus.glitch_cnt = glitch_q;
`else
    assign bus.glitch_cnt = '0;
`endif

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions one raw mechanical input (switch or pushbutton) into a clean, synchronous level for the combinational gate stages downstream (inverter, AND/OR lab gates).
- Sits directly upstream of those gates: a multi-flop synchronizer, then a counter-based debounce FSM.
- Produces a stable level, one-cycle rise/fall pulses and a busy flag.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; must be at least 2.
- DEBOUNCE_CYCLES, 1000, consecutive stable synchronized samples required to accept a new level; must be at least 2.
- RESET_LEVEL, 0, value loaded into synchronizer flops and dout at reset.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din_raw  input  1  raw asynchronous switch input.
- dout  output  1  debounced, synchronized level.
- rise  output  1  one-cycle pulse, coincident with dout going 0->1.
- fall  output  1  one-cycle pulse, coincident with dout going 1->0.
- busy  output  1  high while a candidate level change is being qualified.
- glitch_cnt  output  8  rejected-bounce count (optional feature).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values while rst_n is low:
  - all sync flops = RESET_LEVEL; dout = RESET_LEVEL;
  - rise = fall = busy = 0; counter = 0; glitch_cnt = 0;
  - state = STABLE_HI if RESET_LEVEL is 1, else STABLE_LO.
- Reset release is synchronous-safe: the first state update is on the first clk edge after rst_n rises.
- Synchronizer: din_raw shifts through SYNC_STAGES flops; the last stage (sync_q) is the only signal the FSM reads.
- FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
  - STABLE_LO: sync_q=1 -> CHK_HI, cnt=1. Otherwise stay.
  - CHK_HI, sync_q=1, cnt<DEBOUNCE_CYCLES-1 -> cnt++.
  - CHK_HI, sync_q=1, cnt=DEBOUNCE_CYCLES-1 -> STABLE_HI; dout<=1, rise<=1 on the same edge; cnt<=0.
  - CHK_HI, sync_q=0 -> STABLE_LO, cnt<=0; counts as one glitch.
  - STABLE_HI and CHK_LO mirror the above, with fall and dout<=0.
- busy = 1 exactly when state is CHK_HI or CHK_LO (registered, state-decoded).
- Latency: let edge 1 be the first edge that captures a new din_raw value held steady. dout changes on edge SYNC_STAGES+DEBOUNCE_CYCLES.
- rise/fall are high for exactly one cycle and never both high; dout never toggles twice within DEBOUNCE_CYCLES cycles.
- Boundary conditions:
  - A bounce that returns to the original level on the final qualifying sample (cnt=DEBOUNCE_CYCLES-1, sync_q reverts) is rejected: no dout change.
  - A pulse shorter than one clock may be missed entirely; this is acceptable.
  - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
  - rst_n asserted mid-qualification aborts immediately: outputs go to reset values, no rise/fall is emitted.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt increments by 1 on each CHK_*->STABLE_* abort (a rejected change);
  - saturates at 255; cleared only by reset.
- Undefined: glitch_cnt is tied to 8'd0 and no counter flops are built; the port remains for interface stability.

Decomposition:
- Shared package debounce_pkg holds:
  - state encoding localparams ST_STABLE_LO=2'b00, ST_CHK_HI=2'b01, ST_STABLE_HI=2'b10, ST_CHK_LO=2'b11;
  - GLITCH_W=8 and GLITCH_MAX=8'd255.
- One sub-module: sync_chain (parameters SYNC_STAGES and RESET_LEVEL; ports clk, rst_n, d, q). It is reused for other async lab inputs.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0):
- Reset: hold rst_n=0 with din_raw=1 -> dout=0, rise=fall=busy=0, glitch_cnt=0. Release, keep din_raw=1 -> dout=1 and rise=1 at edge 6; fall stays 0.
- Clean press/release: din_raw 0->1, held 10 cycles, then 1->0.
  - dout rises at edge 6 with a 1-cycle rise pulse.
  - dout falls 6 edges after the release, with a 1-cycle fall pulse.
- Bounce: din_raw high 2 cycles, low 1, high 2, low -> dout stays 0, busy pulses, glitch_cnt=2 (with DEBOUNCE_GLITCH_CNT_EN).
- Last-sample reject: din_raw high for exactly 3 cycles then low -> no rise; glitch_cnt=1.
- Reset mid-CHK: assert rst_n during cnt=2 of a rise qualification -> immediate dout=0, busy=0, no rise; after release, din_raw held 1 -> rise at edge 6.
- Saturation (macro defined): 300 rejected glitches -> glitch_cnt=255; macro undefined -> glitch_cnt=0 throughout.
